proc_run_controller: RTL and testbench
======================================

Name: proc_run_controller

Overview:
- Host-side sequencer for the 8-bit stack processor.
- Per job: clears the processor (reset pulse), streams a program/data image into its memory through the halted-mode direct write port, releases halt for a fixed cycle budget, re-halts, then streams a memory window back through the direct read port.
- Sits between a byte-stream host interface (UART/testbench) and the processor's direct-access and halt/reset pins.

Parameters:
- RUN_W, 16, width of the run-cycle budget and its counter.

Ports:
- clk  in  1  clock
- resetN  in  1  reset
- cmd_start  in  1  start job; sampled only in IDLE
- cmd_abort  in  1  abort job; returns to IDLE from any state
- cfg_load_len  in  9  bytes to load (0..256)
- cfg_run_cycles  in  RUN_W  cycles with processor running
- cfg_dump_base  in  8  first address to read back
- cfg_dump_len  in  9  bytes to read back (0..256)
- in_valid  in  1  load byte valid
- in_data  in  8  load byte
- in_ready  out  1  load byte accepted when in_valid&in_ready
- out_valid  out  1  dump byte valid
- out_data  out  8  dump byte
- out_ready  in  1  dump byte consumed when out_valid&out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on job completion
- proc_resetN  out  1  to processor resetN
- proc_haltN  out  1  to processor haltN
- proc_write_address  out  8  to direct_write_address
- proc_write_data  out  8  to direct_write_data
- proc_memory_write  out  1  to direct_memory_write
- proc_read_address  out  8  to direct_read_address
- proc_read_data  in  8  from direct_read_data

Behaviour:
- Reset: resetN asynchronous, active-low; clock clk, rising edge.
  - All state in IDLE.
  - Counters 0.
  - proc_resetN=0 while resetN low.
  - proc_haltN=0, in_ready=0, out_valid=0, busy=0, done=0, proc_memory_write=0.
- States: IDLE -> CLEAR -> LOAD -> RUN -> DUMP -> FIN -> IDLE.
- IDLE:
  - On cmd_start, latch all cfg_* inputs; the job uses only the latched values.
  - Lengths above 256 clamp to 256.
  - Go to CLEAR.
- CLEAR: exactly 1 cycle.
  - proc_resetN is registered and low exactly during the CLEAR cycle, high otherwise after reset.
  - Processor memory, pc and stack are cleared.
  - Go to LOAD, or to RUN if load_len=0.
- LOAD:
  - in_ready=1.
  - proc_memory_write = in_valid & in_ready (combinational).
  - proc_write_address = load counter (starts at 0).
  - proc_write_data = in_data.
  - Processor captures on the same edge as the handshake; the counter increments on each handshake.
  - After load_len handshakes, go to RUN (or DUMP if run_cycles=0).
  - in_valid gaps stall without side effects.
- RUN:
  - proc_haltN=1 (registered; high exactly while state==RUN).
  - Cycle counter runs from run_cycles down to 1; the processor sees exactly run_cycles rising edges with haltN=1.
  - proc_memory_write=0.
  - Then go to DUMP, or FIN if dump_len=0.
- DUMP:
  - proc_haltN=0.
  - proc_read_address = (dump_base + dump index) mod 256; wraps 255->0.
  - out_valid=1, out_data = proc_read_data (combinational).
  - Address and data hold stable while out_ready=0.
  - Index increments on handshake; after dump_len handshakes go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- cmd_start while busy: ignored.
- cmd_abort:
  - Has priority over all transitions.
  - Next state IDLE; proc_haltN=0 from the next cycle.
  - No done pulse; in-flight handshake in the abort cycle is still honoured.
  - Processor memory is left as-is.
- cmd_start and cmd_abort together in IDLE: abort wins; stay IDLE.
- Outside LOAD: proc_write_* hold 0.
- Outside DUMP: out_valid=0 and proc_read_address=0.
- Async reset mid-job: immediate return to reset values; processor is held in reset.

Test Plan:
- Load/run/dump: load_len=4 bytes {0x01,0x05,0x00,0x03}, run_cycles=3, dump_base=0, dump_len=4 -> proc_resetN low 1 cycle; 4 writes to addr 0..3; haltN high exactly 3 cycles; out bytes equal processor memory 0..3 in order; done single pulse; busy falls the cycle after done.
- Backpressure: in_valid toggling every other cycle and out_ready low 5 cycles mid-dump -> write count stays 4; out_data and proc_read_address stable while stalled; no byte duplicated or dropped.
- Zero lengths: load_len=0, run_cycles=0, dump_len=0 -> CLEAR then FIN; done 2 cycles after start; no writes, haltN never high, out_valid never high.
- Wrap and clamp: dump_base=0xFE, dump_len=4 -> read addresses FE,FF,00,01; cfg_load_len=300 -> exactly 256 writes, addresses 0..255.
- Abort during RUN at cycle 2 of 10 -> haltN low next cycle; state IDLE; no done pulse; a new cmd_start is accepted afterwards.
- Async resetN asserted mid-LOAD -> in_ready, busy and proc_haltN drop immediately; proc_resetN=0 during reset; IDLE after release; cmd_start during busy ignored (config unchanged).

Source files
------------

// File: rtl/proc_run_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : proc_run_controller_if
//  Description : Byte-stream host handshake plus stack-processor direct
//                access / halt / reset pins used by proc_run_controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface proc_run_controller_if;
    // Host load stream
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    // Host dump stream
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    // Processor control and direct memory access
    logic       proc_resetN;
    logic       proc_haltN;
    logic [7:0] proc_write_address;
    logic [7:0] proc_write_data;
    logic       proc_memory_write;
    logic [7:0] proc_read_address;
    logic [7:0] proc_read_data;

    // Controller side
    modport master (
        input  in_valid, in_data, out_ready, proc_read_data,
        output in_ready, out_valid, out_data,
        output proc_resetN, proc_haltN,
        output proc_write_address, proc_write_data, proc_memory_write,
        output proc_read_address
    );

    // Host / processor side
    modport slave (
        output in_valid, in_data, out_ready, proc_read_data,
        input  in_ready, out_valid, out_data,
        input  proc_resetN, proc_haltN,
        input  proc_write_address, proc_write_data, proc_memory_write,
        input  proc_read_address
    );
endinterface
`default_nettype wire

// File: rtl/proc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : proc_run_controller
//  Description : Host-side job sequencer for the 8-bit stack processor:
//                clear, load image, run for a cycle budget, dump a window.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_run_controller #(
    parameter int RUN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             resetN,
    input  wire logic             cmd_start,
    input  wire logic             cmd_abort,
    input  wire logic [8:0]       cfg_load_len,
    input  wire logic [RUN_W-1:0] cfg_run_cycles,
    input  wire logic [7:0]       cfg_dump_base,
    input  wire logic [8:0]       cfg_dump_len,
    output logic                  busy,
    output logic                  done,
    proc_run_controller_if.master bus
);

    localparam logic [8:0]       c_MAX_LEN = 9'd256;
    localparam logic [RUN_W-1:0] c_RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DUMP  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_after_clear;
    state_t           w_after_load;
    state_t           w_after_run;

    logic [8:0]       r_load_len;
    logic [RUN_W-1:0] r_run_cycles;
    logic [7:0]       r_dump_base;
    logic [8:0]       r_dump_len;
    logic [8:0]       r_load_cnt;
    logic [RUN_W-1:0] r_run_cnt;
    logic [8:0]       r_dump_idx;
    logic             r_proc_resetN;
    logic             r_proc_haltN;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_load_hs;
    logic             w_dump_hs;
    logic             w_latch;

    assign w_in_ready  = (r_state == S_LOAD);
    assign w_out_valid = (r_state == S_DUMP);
    assign w_load_hs   = bus.in_valid & w_in_ready;
    assign w_dump_hs   = bus.out_ready & w_out_valid;
    assign w_latch     = (r_state == S_IDLE) & cmd_start;

    // Empty phases are skipped, so each phase's successor depends on later lengths
    assign w_after_run   = (r_dump_len   != 9'd0)          ? S_DUMP : S_FIN;
    assign w_after_load  = (r_run_cycles != {RUN_W{1'b0}}) ? S_RUN  : w_after_run;
    assign w_after_clear = (r_load_len   != 9'd0)          ? S_LOAD : w_after_load;

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_start) w_next = S_CLEAR;
            S_CLEAR: w_next = w_after_clear;
            S_LOAD:  if (w_load_hs && (r_load_cnt + 9'd1 == r_load_len)) w_next = w_after_load;
            S_RUN:   if (r_run_cnt == c_RUN_ONE) w_next = w_after_run;
            S_DUMP:  if (w_dump_hs && (r_dump_idx + 9'd1 == r_dump_len)) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (cmd_abort) begin
            w_next = S_IDLE;
        end
    end

    // State register plus processor reset/halt, registered from the next state
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_proc_resetN <= 1'b0;
            r_proc_haltN  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_proc_resetN <= (w_next != S_CLEAR);
            r_proc_haltN  <= (w_next == S_RUN);
        end
    end

    // Job configuration snapshot, lengths clamped to the 256-byte memory
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_load_len   <= 9'd0;
            r_run_cycles <= {RUN_W{1'b0}};
            r_dump_base  <= 8'd0;
            r_dump_len   <= 9'd0;
        end else if (w_latch) begin
            r_load_len   <= (cfg_load_len > c_MAX_LEN) ? c_MAX_LEN : cfg_load_len;
            r_run_cycles <= cfg_run_cycles;
            r_dump_base  <= cfg_dump_base;
            r_dump_len   <= (cfg_dump_len > c_MAX_LEN) ? c_MAX_LEN : cfg_dump_len;
        end
    end

    // Phase counters; CLEAR always precedes the other phases so it primes them
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_load_cnt <= 9'd0;
            r_run_cnt  <= {RUN_W{1'b0}};
            r_dump_idx <= 9'd0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_load_cnt <= 9'd0;
                    r_dump_idx <= 9'd0;
                    r_run_cnt  <= r_run_cycles;
                end
                S_LOAD:  if (w_load_hs) r_load_cnt <= r_load_cnt + 9'd1;
                S_RUN:   r_run_cnt <= r_run_cnt - c_RUN_ONE;
                S_DUMP:  if (w_dump_hs) r_dump_idx <= r_dump_idx + 9'd1;
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_FIN);

    assign bus.in_ready           = w_in_ready;
    assign bus.proc_memory_write  = w_load_hs;
    assign bus.proc_write_address = w_in_ready ? r_load_cnt[7:0] : 8'd0;
    assign bus.proc_write_data    = w_in_ready ? bus.in_data : 8'd0;

    assign bus.out_valid          = w_out_valid;
    assign bus.proc_read_address  = w_out_valid ? (r_dump_base + r_dump_idx[7:0]) : 8'd0;
    assign bus.out_data           = w_out_valid ? bus.proc_read_data : 8'd0;

    assign bus.proc_resetN        = r_proc_resetN;
    assign bus.proc_haltN         = r_proc_haltN;

endmodule
`default_nettype wire

// File: tb/tb_proc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_run_controller
//  Description : Scoreboard bench for proc_run_controller with a simple
//                processor memory model on the direct access port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_run_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        cmd_start;
    logic        cmd_abort;
    logic [8:0]  cfg_load_len;
    logic [15:0] cfg_run_cycles;
    logic [7:0]  cfg_dump_base;
    logic [8:0]  cfg_dump_len;
    logic        busy;
    logic        done;

    proc_run_controller_if ifc ();

    proc_run_controller #(.RUN_W(16)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cfg_load_len   (cfg_load_len),
        .cfg_run_cycles (cfg_run_cycles),
        .cfg_dump_base  (cfg_dump_base),
        .cfg_dump_len   (cfg_dump_len),
        .busy           (busy),
        .done           (done),
        .bus            (ifc)
    );

    always #5 clk = ~clk;

    // Processor memory: cleared while proc_resetN low, written through direct port
    logic [7:0] pmem [256];
    always @(posedge clk) begin
        if (!ifc.proc_resetN) begin
            for (int i = 0; i < 256; i++) pmem[i] <= 8'h00;
        end else if (ifc.proc_memory_write) begin
            pmem[ifc.proc_write_address] <= ifc.proc_write_data;
        end
    end
    assign ifc.proc_read_data = pmem[ifc.proc_read_address];

    int n_chk = 0;
    int n_err = 0;
    int n_writes, n_halt, n_rstlo, n_done, n_ov;
    logic [15:0] exp_wq [$];
    logic [15:0] exp_dq [$];
    logic [7:0]  ld [256];
    logic [15:0] mon_e;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_cnt();
        n_writes = 0; n_halt = 0; n_rstlo = 0; n_done = 0; n_ov = 0;
    endtask

    // Monitor: pops the expected write/dump queues whenever the DUT presents a transfer
    always @(negedge clk) begin
        if (resetN) begin
            if (ifc.proc_haltN)   n_halt++;
            if (!ifc.proc_resetN) n_rstlo++;
            if (done)             n_done++;
            if (ifc.proc_memory_write) begin
                n_writes++;
                if (exp_wq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL wr_unexpected: got addr 0x%0h, no write expected", ifc.proc_write_address);
                end else begin
                    mon_e = exp_wq.pop_front();
                    chk("wr_addr", ifc.proc_write_address, mon_e[15:8]);
                    chk("wr_data", ifc.proc_write_data, mon_e[7:0]);
                end
            end
            if (ifc.out_valid) begin
                n_ov++;
                if (exp_dq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL dump_unexpected: got addr 0x%0h, no dump expected", ifc.proc_read_address);
                end else begin
                    mon_e = exp_dq[0];
                    chk("dump_addr", ifc.proc_read_address, mon_e[15:8]);
                    chk("dump_data", ifc.out_data, mon_e[7:0]);
                    if (ifc.out_ready) void'(exp_dq.pop_front());
                end
            end
        end
    end

    task automatic fill(input int s);
        for (int i = 0; i < 256; i++) ld[i] = 8'((i * 37 + s) & 255);
    endtask

    task automatic run_job(input int ll, input int rc, input int db, input int dl,
                           input bit gap, input bit stall, input bit poke,
                           input int abort_at, input int exp_done_cyc);
        int eff, edl, a, idx, cyc, ndump, stallc, done_cyc;
        bit hs, saw_done, aborted, ab_done;
        logic [7:0] d;
        eff = (ll > 256) ? 256 : ll;
        edl = (dl > 256) ? 256 : dl;
        clear_cnt();
        for (int i = 0; i < eff; i++) exp_wq.push_back({8'(i), ld[i]});
        for (int i = 0; i < edl; i++) begin
            a = (db + i) % 256;
            d = (a < eff) ? ld[a] : 8'h00;
            exp_dq.push_back({8'(a), d});
        end
        cfg_load_len = 9'(ll); cfg_run_cycles = 16'(rc);
        cfg_dump_base = 8'(db); cfg_dump_len = 9'(dl);
        ifc.out_ready = 1'b1;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        // Load phase driver
        idx = 0; cyc = 0;
        while (idx < eff && cyc < 2000) begin
            if (poke && cyc == 0) begin
                cmd_start = 1'b1; cfg_load_len = 9'd1; cfg_dump_len = 9'd1;
                cfg_run_cycles = 16'd7; cfg_dump_base = 8'h80;
            end else begin
                cmd_start = 1'b0;
            end
            ifc.in_valid = gap ? (cyc % 2 == 1) : 1'b1;
            ifc.in_data  = ld[idx];
            @(negedge clk);
            hs = ifc.in_valid && ifc.in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        cmd_start = 1'b0;
        ifc.in_valid = 1'b0;
        chk("load_complete", idx, eff);
        // Run / dump / completion driver
        cyc = 0; ndump = 0; stallc = 0; done_cyc = -1;
        saw_done = 0; aborted = 0; ab_done = 0;
        while (!saw_done && !ab_done && cyc < 2000) begin
            ifc.out_ready = !(stall && ndump == 2 && stallc < 5);
            cmd_abort = (abort_at > 0 && !aborted && ifc.proc_haltN && n_halt == abort_at - 1);
            if (cmd_abort) aborted = 1;
            @(negedge clk);
            if (ifc.out_valid && ifc.out_ready) ndump++;
            if (ifc.out_valid && !ifc.out_ready) stallc++;
            if (done) begin saw_done = 1; done_cyc = cyc; end
            @(posedge clk); #1;
            cyc++;
            if (aborted && !ab_done) begin cmd_abort = 1'b0; ab_done = 1; end
        end
        ifc.out_ready = 1'b1;
        if (abort_at > 0) begin
            chk("abort_taken", ab_done, 1);
            @(negedge clk);
            chk("abort_haltN", ifc.proc_haltN, 0);
            chk("abort_busy", busy, 0);
            repeat (3) @(negedge clk);
            chk("abort_no_done", n_done, 0);
            chk("abort_halt_cycles", n_halt, abort_at);
            chk("abort_no_out_valid", n_ov, 0);
            chk("abort_writes", n_writes, eff);
            exp_dq.delete();
        end else begin
            chk("done_seen", saw_done, 1);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            repeat (2) @(negedge clk);
            chk("done_pulses", n_done, 1);
            chk("halt_cycles", n_halt, rc);
            chk("proc_reset_cycles", n_rstlo, 1);
            chk("write_count", n_writes, eff);
            chk("out_valid_cycles", n_ov, edl + (stall ? 5 : 0));
            chk("dump_queue_left", exp_dq.size(), 0);
            if (exp_done_cyc >= 0) chk("done_latency", done_cyc, exp_done_cyc);
        end
        chk("write_queue_left", exp_wq.size(), 0);
        exp_wq.delete();
        @(posedge clk); #1;
    endtask

    // Directed job sequence
    initial begin
        int k;
        resetN = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
        cfg_load_len = 9'd0; cfg_run_cycles = 16'd0; cfg_dump_base = 8'd0; cfg_dump_len = 9'd0;
        ifc.in_valid = 1'b0; ifc.in_data = 8'd0; ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_haltN", ifc.proc_haltN, 0);
        chk("rst_proc_resetN", ifc.proc_resetN, 0);
        chk("rst_mem_write", ifc.proc_memory_write, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic load/run/dump
        fill(3);
        ld[0] = 8'h01; ld[1] = 8'h05; ld[2] = 8'h00; ld[3] = 8'h03;
        run_job(4, 3, 0, 4, 0, 0, 0, 0, -1);
        // Backpressure both sides plus start while busy
        fill(11);
        run_job(4, 3, 0, 6, 1, 1, 1, 0, -1);
        // All phases empty
        run_job(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Load length clamp and dump address wrap
        fill(90);
        run_job(300, 2, 8'hFE, 4, 0, 0, 0, 0, -1);
        // Abort in second run cycle, then a fresh job
        fill(5);
        run_job(2, 10, 0, 4, 0, 0, 0, 2, -1);
        fill(200);
        run_job(3, 1, 0, 3, 0, 0, 0, 0, -1);

        // Asynchronous reset in the middle of LOAD
        fill(17);
        clear_cnt();
        for (int i = 0; i < 8; i++) exp_wq.push_back({8'(i), ld[i]});
        cfg_load_len = 9'd8; cfg_run_cycles = 16'd2; cfg_dump_base = 8'd0; cfg_dump_len = 9'd2;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_data = ld[0];
        k = 0;
        while (n_writes < 3 && k < 50) begin
            @(negedge clk);
            @(posedge clk); #1;
            ifc.in_data = ld[n_writes];
            k++;
        end
        chk("mid_load_writes", n_writes, 3);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_in_ready", ifc.in_ready, 0);
        chk("async_busy", busy, 0);
        chk("async_haltN", ifc.proc_haltN, 0);
        chk("async_proc_resetN", ifc.proc_resetN, 0);
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_proc_resetN", ifc.proc_resetN, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_proc_resetN", ifc.proc_resetN, 1);
        chk("post_rst_write_count", n_writes, 3);
        exp_wq.delete();
        exp_dq.delete();
        @(posedge clk); #1;
        fill(60);
        run_job(2, 2, 1, 2, 0, 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
